// File: rtl/race_referee.sv
// Red-light/green-light race referee: times the light phases, checks finish-line crossings and
// catches the player moving on red, keeping saturating win tallies across rounds.
module race_referee #(
    parameter logic [9:0]  FINISH_X   = 10'd580,
    parameter logic [27:0] GREEN_BASE = 28'd100_000_000,
    parameter logic [27:0] RED_TIME   = 28'd75_000_000,
    parameter logic [27:0] GRACE      = 28'd10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] rand_val,
    input  logic [9:0]  player_x,
    input  logic [8:0]  player_y,
    input  logic [9:0]  ai1_x,
    input  logic [9:0]  ai2_x,
    input  logic [9:0]  ai3_x,
    output logic        game_active,
    output logic        light_green,
    output logic        player_out,
    output logic [2:0]  winner,
    output logic [3:0]  player_wins,
    output logic [3:0]  ai_wins
);

    typedef enum logic [2:0] {
        StIdle,
        StGreen,
        StGraceRed,
        StRed,
        StDone
    } state_t;

    state_t      state_q, state_d;
    logic [27:0] phase_q, phase_d;
    logic [27:0] red_q, red_d;
    logic [27:0] green_len_q, green_len_d;
    logic [9:0]  snap_x_q, snap_x_d;
    logic [8:0]  snap_y_q, snap_y_d;
    logic [1:0]  blank_q, blank_d;
    logic [1:0]  rst_sync_q;
    logic        start_prev_q;

    logic        player_out_d;
    logic [2:0]  winner_d;
    logic [3:0]  player_wins_d, ai_wins_d;
    logic        game_active_d, light_green_d;

    logic        start_edge;
    logic [27:0] green_len_new;
    logic        checks_on;
    logic        moved;
    logic        fin_hit;
    logic [2:0]  fin_winner;
    logic        unused_rand;

    assign unused_rand = ^rand_val[15:5];

    // rst_sync_q gates start so a start level present at reset release is not taken too early.
    assign start_edge    = start & ~start_prev_q & rst_sync_q[1];
    assign green_len_new = GREEN_BASE + {3'd0, rand_val[4:0], 20'd0};
    assign checks_on     = (blank_q == 2'd0);
    assign moved         = (player_x != snap_x_q) || (player_y != snap_y_q);

    always_comb begin
        fin_hit    = 1'b1;
        fin_winner = 3'd0;
        if (player_x >= FINISH_X) begin
            fin_winner = 3'd1;
        end else if (ai1_x >= FINISH_X) begin
            fin_winner = 3'd2;
        end else if (ai2_x >= FINISH_X) begin
            fin_winner = 3'd3;
        end else if (ai3_x >= FINISH_X) begin
            fin_winner = 3'd4;
        end else begin
            fin_hit = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        red_d         = red_q;
        green_len_d   = green_len_q;
        snap_x_d      = snap_x_q;
        snap_y_d      = snap_y_q;
        blank_d       = blank_q;
        player_out_d  = player_out;
        winner_d      = winner;
        player_wins_d = player_wins;
        ai_wins_d     = ai_wins;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_edge) begin
                    state_d      = StGreen;
                    phase_d      = 28'd0;
                    red_d        = 28'd0;
                    green_len_d  = green_len_new;
                    blank_d      = 2'd2;
                    player_out_d = 1'b0;
                    winner_d     = 3'd0;
                end
            end
            StGreen, StGraceRed, StRed: begin
                if (phase_q != '1) phase_d = phase_q + 28'd1;
                if (state_q != StGreen && red_q != '1) red_d = red_q + 28'd1;
                if (blank_q != 2'd0) blank_d = blank_q - 2'd1;

                if (state_q == StGreen && phase_q == green_len_q - 28'd1) begin
                    state_d = StGraceRed;
                    phase_d = 28'd0;
                    red_d   = 28'd0;
                end else if (state_q == StGraceRed && phase_q == GRACE - 28'd1) begin
                    state_d  = StRed;
                    phase_d  = 28'd0;
                    snap_x_d = player_x;
                    snap_y_d = player_y;
                end else if (state_q == StRed && red_q == RED_TIME - 28'd1) begin
                    state_d     = StGreen;
                    phase_d     = 28'd0;
                    green_len_d = green_len_new;
                end

                // A movement penalty outranks a finish seen in the same cycle.
                if (checks_on) begin
                    if (state_q == StRed && moved) begin
                        state_d      = StDone;
                        player_out_d = 1'b1;
                        winner_d     = 3'd0;
                    end else if (fin_hit) begin
                        state_d  = StDone;
                        winner_d = fin_winner;
                    end
                end

                if (state_d == StDone) begin
                    phase_d = 28'd0;
                    red_d   = 28'd0;
                    if (winner_d == 3'd1 && player_wins != 4'd15) begin
                        player_wins_d = player_wins + 4'd1;
                    end
                    if ((winner_d >= 3'd2 || player_out_d) && ai_wins != 4'd15) begin
                        ai_wins_d = ai_wins + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        game_active_d = (state_d == StGreen) || (state_d == StGraceRed) || (state_d == StRed);
        light_green_d = (state_d == StGreen);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            phase_q      <= 28'd0;
            red_q        <= 28'd0;
            green_len_q  <= GREEN_BASE;
            snap_x_q     <= 10'd0;
            snap_y_q     <= 9'd0;
            blank_q      <= 2'd0;
            rst_sync_q   <= 2'b00;
            start_prev_q <= 1'b0;
            game_active  <= 1'b0;
            light_green  <= 1'b0;
            player_out   <= 1'b0;
            winner       <= 3'd0;
            player_wins  <= 4'd0;
            ai_wins      <= 4'd0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            red_q        <= red_d;
            green_len_q  <= green_len_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            blank_q      <= blank_d;
            rst_sync_q   <= {rst_sync_q[0], 1'b1};
            start_prev_q <= start;
            game_active  <= game_active_d;
            light_green  <= light_green_d;
            player_out   <= player_out_d;
            winner       <= winner_d;
            player_wins  <= player_wins_d;
            ai_wins      <= ai_wins_d;
        end
    end

endmodule
